mem_access_ctrl: RTL and testbench

Sequences data-memory accesses issued from the MEM stage against a memory port that can take multiple cycles (valid/ready style). The EX/MEM pipeline register and all upstream pipeline registers are held via StallM until the access completes. The block also generates byte enables and write-lane replication, and performs load extraction with sign/zero extension. It sits between the EX/MEM register outputs and the data memory; StallM feeds the EN (hold-when-high) inputs of the pipeline registers.

---
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: holds the pipeline while a multi-cycle
// valid/ready access completes, and builds byte enables, store lanes and load extension.
module mem_access_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT3_WIDTH = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MemReadM,
  input  logic                    MemWriteM,
  input  logic [FUNCT3_WIDTH-1:0] funct3M,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_be,
  output logic                    StallM,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  output logic                    MisalignM,
  output logic                    MemErrM
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [3:0]                be_q, be_d;
  logic                      we_q, we_d;
  logic                      err_q, err_d;
  logic [FUNCT3_WIDTH-1:0]   f3_q, f3_d;
  logic [1:0]                off_q, off_d;

  logic access;
  logic misaligned;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off,
                                         input logic wr);
    return (f3[1:0] == 2'b01 && off[0]) ||
           (f3[1:0] == 2'b10 && off != 2'b00) ||
           (f3[1:0] == 2'b11) ||
           (wr && f3[2]);
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_rep(input logic [1:0] size,
                                                     input logic [DATA_WIDTH-1:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] rd,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
    logic [DATA_WIDTH-1:0] s;
    s = rd >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return rd;
    endcase
  endfunction

  assign access     = MemReadM | MemWriteM;
  assign misaligned = is_misaligned(funct3M, ALUResultM[1:0], MemWriteM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    be_d      = be_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    err_d     = 1'b0;
    mem_req   = 1'b0;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            MisalignM = 1'b1;
          end else begin
            StallM  = 1'b1;
            addr_d  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            we_d    = MemWriteM;
            be_d    = byte_en(funct3M[1:0], ALUResultM[1:0]);
            wdata_d = lane_rep(funct3M[1:0], WriteDataM);
            f3_d    = funct3M;
            off_d   = ALUResultM[1:0];
            cnt_d   = 8'd0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        StallM  = 1'b1;
        if (mem_ready) begin
          if (!we_q) rdata_d = load_ext(mem_rdata, f3_q, off_q);
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Abandoned access: surface an error and release the pipeline with a zero result.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      off_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign ReadDataM = rdata_q;
  assign MemErrM   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs change 1ns after the rising edge,
// outputs are checked 1ns later.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM, MemErrM;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .MemErrM(MemErrM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
  endtask

  initial begin
    RST = 1'b1;
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    cyc(); cyc();
    RST = 1'b0;
    #1;
    chk("rst_req",   {31'd0, mem_req},   32'd0);
    chk("rst_stall", {31'd0, StallM},    32'd0);
    chk("rst_rdata", ReadDataM,          32'd0);
    chk("rst_addr",  mem_addr,           32'd0);
    chk("rst_be",    {28'd0, mem_be},    32'd0);
    chk("rst_err",   {31'd0, MemErrM},   32'd0);

    // LW 0x100, immediate ready
    cyc();
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    chk("lw_idle_stall", {31'd0, StallM},  32'd1);
    chk("lw_idle_req",   {31'd0, mem_req}, 32'd0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req",   {31'd0, mem_req}, 32'd1);
    chk("lw_stall", {31'd0, StallM},  32'd1);
    chk("lw_be",    {28'd0, mem_be},  32'hF);
    chk("lw_addr",  mem_addr,         32'h100);
    chk("lw_we",    {31'd0, mem_we},  32'd0);
    cyc();
    mem_ready = 1'b0; issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("lw_done_stall", {31'd0, StallM},  32'd0);
    chk("lw_done_req",   {31'd0, mem_req}, 32'd0);
    chk("lw_rdata",      ReadDataM,        32'hDEADBEEF);
    cyc();

    // LB 0x203, then LBU 0x203
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h203, 32'h0);
      #1;
      chk("lb_idle_stall", {31'd0, StallM}, 32'd1);
      cyc();
      mem_ready = 1'b1; mem_rdata = 32'h80FFFF7F;
      #1;
      chk("lb_addr", mem_addr,        32'h200);
      chk("lb_be",   {28'd0, mem_be}, 32'h8);
      cyc();
      mem_ready = 1'b0; issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      chk(k == 0 ? "lb_rdata" : "lbu_rdata", ReadDataM,
          (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      cyc();
    end

    // SH 0x302, ready in the third REQ cycle
    issue(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD);
    #1;
    chk("sh_idle_stall", {31'd0, StallM}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk("sh_req",   {31'd0, mem_req}, 32'd1);
      chk("sh_stall", {31'd0, StallM},  32'd1);
      chk("sh_we",    {31'd0, mem_we},  32'd1);
      chk("sh_be",    {28'd0, mem_be},  32'hC);
      chk("sh_wdata", mem_wdata,        32'hABCDABCD);
      chk("sh_addr",  mem_addr,         32'h300);
    end
    cyc();
    mem_ready = 1'b0; issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("sh_done_stall", {31'd0, StallM}, 32'd0);
    chk("sh_rdata_kept", ReadDataM,       32'h00000080);
    cyc();

    // Misaligned LW 0x101
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    #1;
    chk("mis_pulse", {31'd0, MisalignM}, 32'd1);
    chk("mis_stall", {31'd0, StallM},    32'd0);
    chk("mis_req",   {31'd0, mem_req},   32'd0);
    cyc();
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("mis_req2",  {31'd0, mem_req},   32'd0);
    chk("mis_clear", {31'd0, MisalignM}, 32'd0);
    cyc();

    // Reset during the second REQ cycle
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    cyc();
    cyc();
    #1;
    chk("rstreq_req", {31'd0, mem_req}, 32'd1);
    RST = 1'b1;
    cyc();
    RST = 1'b0; issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("rstreq_req0",  {31'd0, mem_req}, 32'd0);
    chk("rstreq_stall", {31'd0, StallM},  32'd0);
    chk("rstreq_err",   {31'd0, MemErrM}, 32'd0);
    chk("rstreq_rdata", ReadDataM,        32'd0);
    cyc();
    chk("rstreq_err2",  {31'd0, MemErrM}, 32'd0);
    chk("rstreq_req1",  {31'd0, mem_req}, 32'd0);

    // LW 0x400 that never gets ready: timeout
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    mem_rdata = 32'h5555AAAA;
    #1;
    chk("to_idle_stall", {31'd0, StallM}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      #1;
      chk("to_req",   {31'd0, mem_req}, 32'd1);
      chk("to_noerr", {31'd0, MemErrM}, 32'd0);
    end
    cyc();
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("to_err",   {31'd0, MemErrM}, 32'd1);
    chk("to_rdata", ReadDataM,        32'd0);
    chk("to_stall", {31'd0, StallM},  32'd0);
    chk("to_req0",  {31'd0, mem_req}, 32'd0);
    cyc();
    #1;
    chk("to_err_pulse", {31'd0, MemErrM}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
